// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with valid/ready handshake, flush and saturating stall counter.
// Define ID_EX_SKID_EN to add a skid entry that gives a fully registered in_ready.
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic [WB_W-1:0]   ctl_wb,
    input  logic [M_W-1:0]    ctl_m,
    input  logic [3:0]        ctl_ex,
    input  logic [DATA_W-1:0] npc,
    input  logic [DATA_W-1:0] read_data_1,
    input  logic [DATA_W-1:0] read_data_2,
    input  logic [DATA_W-1:0] sign_ext,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WB_W-1:0]   wb_ctl_out,
    output logic [M_W-1:0]    m_ctl_out,
    output logic              reg_dest,
    output logic [1:0]        alu_op,
    output logic              alu_src,
    output logic [DATA_W-1:0] npc_out,
    output logic [DATA_W-1:0] r_data_1_out,
    output logic [DATA_W-1:0] r_data_2_out,
    output logic [DATA_W-1:0] sign_extend_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [3:0]        ex;
        logic [DATA_W-1:0] npc;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t   state_q, state_d;
    payload_t pay_in, out_q;
    logic     accept, consume, load_out;

    assign pay_in = {ctl_wb, ctl_m, ctl_ex, npc, read_data_1, read_data_2,
                     sign_ext, rt_in, rd_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_d = FULL;
                FULL: begin
                    if (consume && !accept) state_d = EMPTY;
`ifdef ID_EX_SKID_EN
                    if (accept && !consume) state_d = SKID;
`endif
                end
`ifdef ID_EX_SKID_EN
                SKID: if (consume) state_d = FULL;
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
`ifdef ID_EX_SKID_EN
        in_ready  = (state_q != SKID);
`else
        in_ready  = !out_valid || out_ready;
`endif
        accept    = in_valid && in_ready;
        consume   = out_valid && out_ready;
        // Output register takes the incoming word only when it is free this cycle.
        load_out  = accept && ((state_q == EMPTY) || consume);
    end

`ifdef ID_EX_SKID_EN
    payload_t skid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush) begin
            skid_q <= '0;
        end else begin
            if (state_q == SKID) begin
                if (consume) out_q <= skid_q;
            end else if (load_out) begin
                out_q <= pay_in;
            end
            if (state_q == FULL && accept && !consume) skid_q <= pay_in;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else if (!flush && load_out) begin
            out_q <= pay_in;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // Control fields read as a bubble whenever no payload is presented.
    assign wb_ctl_out      = out_valid ? out_q.wb : '0;
    assign m_ctl_out       = out_valid ? out_q.m  : '0;
    assign reg_dest        = out_q.ex[3];
    assign alu_op          = out_q.ex[2:1];
    assign alu_src         = out_q.ex[0];
    assign npc_out         = out_q.npc;
    assign r_data_1_out    = out_q.rd1;
    assign r_data_2_out    = out_q.rd2;
    assign sign_extend_out = out_q.imm;
    assign rt_out          = out_q.rt;
    assign rd_out          = out_q.rd;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe against a queue-based model of the stage.
module tb_id_ex_pipe;
    localparam int CW = 4;
`ifdef ID_EX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [3:0]  ex;
        logic [31:0] npc;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] se;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } pay_t;

    logic clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [1:0] ctl_wb, wb_ctl_out, alu_op;
    logic [2:0] ctl_m, m_ctl_out;
    logic [3:0] ctl_ex;
    logic [31:0] npc, read_data_1, read_data_2, sign_ext;
    logic [31:0] npc_out, r_data_1_out, r_data_2_out, sign_extend_out;
    logic [4:0] rt_in, rd_in, rt_out, rd_out;
    logic reg_dest, alu_src;
    logic [CW-1:0] stall_cycles;

    pay_t din;
    pay_t mq[$];
    int unsigned mstall;
    int n_cmp, n_err;

    assign ctl_wb = din.wb;
    assign ctl_m = din.m;
    assign ctl_ex = din.ex;
    assign npc = din.npc;
    assign read_data_1 = din.r1;
    assign read_data_2 = din.r2;
    assign sign_ext = din.se;
    assign rt_in = din.rt;
    assign rd_in = din.rd;

    id_ex_pipe #(.DATA_W(32), .REG_W(5), .WB_W(2), .M_W(3), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .ctl_wb(ctl_wb), .ctl_m(ctl_m), .ctl_ex(ctl_ex),
        .npc(npc), .read_data_1(read_data_1), .read_data_2(read_data_2),
        .sign_ext(sign_ext), .rt_in(rt_in), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_ctl_out(wb_ctl_out), .m_ctl_out(m_ctl_out),
        .reg_dest(reg_dest), .alu_op(alu_op), .alu_src(alu_src),
        .npc_out(npc_out), .r_data_1_out(r_data_1_out),
        .r_data_2_out(r_data_2_out), .sign_extend_out(sign_extend_out),
        .rt_out(rt_out), .rd_out(rd_out), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pay_t rnd_pay();
        pay_t p;
        p.wb = 2'($urandom);
        p.m = 3'($urandom);
        p.ex = 4'($urandom);
        p.npc = $urandom;
        p.r1 = $urandom;
        p.r2 = $urandom;
        p.se = $urandom;
        p.rt = 5'($urandom);
        p.rd = 5'($urandom);
        return p;
    endfunction

    function automatic pay_t got();
        pay_t p;
        p = {wb_ctl_out, m_ctl_out, reg_dest, alu_op, alu_src, npc_out,
             r_data_1_out, r_data_2_out, sign_extend_out, rt_out, rd_out};
        return p;
    endfunction

    // Capacity-based view of readiness: room left, or the head leaves this cycle.
    function automatic bit exp_ready();
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || out_ready;
    endfunction

    task automatic drive(input bit v, input bit r, input bit f);
        in_valid = v;
        out_ready = r;
        flush = f;
        din = rnd_pay();
        #1;
    endtask

    task automatic tick();
        bit acc, con;
        acc = in_valid && exp_ready();
        con = (mq.size() > 0) && out_ready;
        if (mq.size() > 0 && !out_ready && mstall < (2 ** CW) - 1) mstall++;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mstall = 0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back(din);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid);
        end
        n_cmp++;
        if (got() !== pay_t'(0)) begin
            n_err++; $display("FAIL reset_payload: got %h want 0", got());
        end
        n_cmp++;
        if (stall_cycles !== '0) begin
            n_err++; $display("FAIL reset_stall: got %0d want 0", stall_cycles);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_first();
        drive(1'b1, 1'b1, 1'b0);
        din.npc = 32'h0000_0004;
        din.ex = 4'b1101;
        tick();
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || npc_out !== 32'h4) begin
            n_err++; $display("FAIL first_npc: got v=%0b npc=%h want v=1 npc=4", out_valid, npc_out);
        end
        n_cmp++;
        if ({reg_dest, alu_op, alu_src} !== 4'b1101) begin
            n_err++; $display("FAIL first_ctl_ex: got %b want 1101", {reg_dest, alu_op, alu_src});
        end
        tick();
    endtask

    task automatic test_stream();
        pay_t sent[8];
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            sent[i] = din;
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || got() !== sent[i]) begin
                n_err++; $display("FAIL stream_%0d: got v=%0b %h want v=1 %h", i, out_valid, got(), sent[i]);
            end
        end
        drive(1'b0, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_end_valid: got %0b want 0", out_valid);
        end
        n_cmp++;
        if (stall_cycles !== '0) begin
            n_err++; $display("FAIL stream_stall: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_backpressure();
        pay_t first;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        first = din;
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (in_ready !== ((CAP == 2) && (k == 0))) begin
                n_err++; $display("FAIL bp_in_ready_%0d: got %0b want %0b", k, in_ready, (CAP == 2) && (k == 0));
            end
            n_cmp++;
            if (out_valid !== 1'b1 || got() !== first) begin
                n_err++; $display("FAIL bp_hold_%0d: got %h want %h", k, got(), first);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (stall_cycles !== CW'(5)) begin
            n_err++; $display("FAIL bp_stall: got %0d want 5", stall_cycles);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (mq.size() > 0) begin
                n_cmp++;
                if (out_valid !== 1'b1 || got() !== mq[0]) begin
                    n_err++; $display("FAIL bp_drain_%0d: got %h want %h", i, got(), mq[0]);
                end
            end
            tick();
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drained: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1);
        din.wb = 2'b11;
        din.m = 3'b101;
        tick();
        drive(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0 || wb_ctl_out !== 2'b00 || m_ctl_out !== 3'b000) begin
            n_err++; $display("FAIL flush_bubble: got v=%0b wb=%b m=%b want 0 00 000", out_valid, wb_ctl_out, m_ctl_out);
        end
        n_cmp++;
        if (stall_cycles !== CW'(mstall)) begin
            n_err++; $display("FAIL flush_stall: got %0d want %0d", stall_cycles, mstall);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_skid_empty: got %0b want 0", out_valid);
        end
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            tick();
        end
        n_cmp++;
        if (stall_cycles !== 4'hF) begin
            n_err++; $display("FAIL sat_stall: got %0d want 15", stall_cycles);
        end
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (stall_cycles !== '0 || out_valid !== 1'b0 || got() !== pay_t'(0)) begin
            n_err++; $display("FAIL sat_reset: got stall=%0d v=%0b pay=%h want all 0", stall_cycles, out_valid, got());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
            n_cmp++;
            if (out_valid !== (mq.size() > 0) || in_ready !== exp_ready()) begin
                n_err++; $display("FAIL rnd_hs_%0d: got v=%0b r=%0b want v=%0b r=%0b", i, out_valid, in_ready, mq.size() > 0, exp_ready());
            end
            n_cmp++;
            if (mq.size() > 0) begin
                if (got() !== mq[0]) begin
                    n_err++; $display("FAIL rnd_pay_%0d: got %h want %h", i, got(), mq[0]);
                end
            end else if ({wb_ctl_out, m_ctl_out} !== 5'b0) begin
                n_err++; $display("FAIL rnd_bubble_%0d: got %b want 0", i, {wb_ctl_out, m_ctl_out});
            end
            n_cmp++;
            if (stall_cycles !== CW'(mstall)) begin
                n_err++; $display("FAIL rnd_stall_%0d: got %0d want %0d", i, stall_cycles, mstall);
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        mstall = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        din = '0;
        test_reset();
        test_first();
        test_stream();
        test_backpressure();
        test_flush();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
